// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - buffers (activation, weight) pairs and holds each on the bit-serial MAC for N cycles
module mac_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int WW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_act,
    input  logic [WW-1:0] in_wgt,
    input  logic          in_last,
    input  logic [1:0]    prec_level,
    output logic [AW-1:0] mac_activation,
    output logic [WW-1:0] mac_weight,
    output logic          mac_en,
    output logic [1:0]    mac_prec,
    output logic          group_done,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + WW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, PAD} state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d, bit_cnt_q, bit_cnt_d;
    logic          mac_en_q, mac_en_d, last_q, last_d, group_done_q, group_done_d;
    logic [AW-1:0] mac_act_q, mac_act_d;
    logic [WW-1:0] mac_wgt_q, mac_wgt_d;
    logic [1:0]    mac_prec_q, mac_prec_d;

    logic          empty, full, push, pop, do_decide, can_switch;
    logic [2:0]    phase_nxt;
    logic [EW-1:0] head;

    function automatic logic [2:0] last_bit(input logic [1:0] p);
        case (p)
            2'b00:   last_bit = 3'd7;
            2'b10:   last_bit = 3'd1;
            default: last_bit = 3'd3;
        endcase
    endfunction

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q[PW-1:0]];
    assign in_ready = !full;
    assign busy     = (state_q != IDLE) || !empty;

    assign mac_activation = mac_act_q;
    assign mac_weight     = mac_wgt_q;
    assign mac_en         = mac_en_q;
    assign mac_prec       = mac_prec_q;
    assign group_done     = group_done_q;

    // Phase the MAC counter will hold after this edge; precision may only change when it is 0.
    assign phase_nxt  = mac_en_q ? phase_q + 3'd1 : phase_q;
    assign can_switch = (prec_level == mac_prec_q) || (phase_nxt == 3'd0);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_nxt;
        bit_cnt_d    = bit_cnt_q;
        mac_en_d     = mac_en_q;
        mac_act_d    = mac_act_q;
        mac_wgt_d    = mac_wgt_q;
        mac_prec_d   = mac_prec_q;
        last_d       = last_q;
        group_done_d = 1'b0;
        pop          = 1'b0;
        do_decide    = 1'b0;

        case (state_q)
            IDLE: begin
                mac_en_d = 1'b0;
                if (!empty) do_decide = 1'b1;
            end
            ISSUE: begin
                if (bit_cnt_q == last_bit(mac_prec_q)) begin
                    group_done_d = last_q;
                    if (!empty) begin
                        do_decide = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        mac_en_d = 1'b0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PAD: begin
                if (phase_nxt == 3'd0) begin
                    mac_prec_d = prec_level;
                    if (!empty) begin
                        do_decide = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        mac_en_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_decide) begin
            mac_en_d = 1'b1;
            if (can_switch) begin
                mac_prec_d = prec_level;
                pop        = 1'b1;
                state_d    = ISSUE;
                bit_cnt_d  = 3'd0;
                mac_act_d  = head[AW-1:0];
                mac_wgt_d  = head[AW+WW-1:AW];
                last_d     = head[EW-1];
            end else begin
                state_d   = PAD;
                mac_act_d = '0;
                mac_wgt_d = '0;
                last_d    = 1'b0;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= {in_last, in_wgt, in_act};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            phase_q      <= 3'd0;
            bit_cnt_q    <= 3'd0;
            mac_en_q     <= 1'b0;
            mac_act_q    <= '0;
            mac_wgt_q    <= '0;
            mac_prec_q   <= 2'b00;
            last_q       <= 1'b0;
            group_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            mac_en_q     <= mac_en_d;
            mac_act_q    <= mac_act_d;
            mac_wgt_q    <= mac_wgt_d;
            mac_prec_q   <= mac_prec_d;
            last_q       <= last_d;
            group_done_q <= group_done_d;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_act;
    logic [7:0] in_wgt;
    logic       in_last;
    logic [1:0] prec_level;
    logic [7:0] mac_activation;
    logic [7:0] mac_weight;
    logic       mac_en;
    logic [1:0] mac_prec;
    logic       group_done;
    logic       busy;

    mac_operand_feeder #(.DEPTH(4), .AW(8), .WW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_act         (in_act),
        .in_wgt         (in_wgt),
        .in_last        (in_last),
        .prec_level     (prec_level),
        .mac_activation (mac_activation),
        .mac_weight     (mac_weight),
        .mac_en         (mac_en),
        .mac_prec       (mac_prec),
        .group_done     (group_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation counters, all cumulative; each test works from a snapshot.
    int         en_cnt = 0, gd_cnt = 0, bursts = 0, pad_cnt = 0, p0_cnt = 0, full_seen = 0;
    int         acc = 0, log_n = 0;
    logic [7:0] act_log [32];
    logic [7:0] last_act = 8'h00;
    logic [2:0] mcnt = 3'd0;
    logic       prev_en = 1'b0;

    int b_en, b_gd, b_bursts, b_pad, b_p0, b_full, b_acc, b_log;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mcnt     = 3'd0;
            last_act = 8'h00;
            prev_en  = 1'b0;
        end else begin
            if (mac_en) begin
                if (!prev_en) bursts++;
                en_cnt++;
                if (mac_weight[mcnt]) acc += int'(mac_activation) << mcnt;
                if (mac_activation != 8'h00 && mac_activation != last_act) begin
                    act_log[log_n] = mac_activation;
                    log_n++;
                end
                last_act = mac_activation;
                if (mac_activation == 8'h00 && mac_weight == 8'h00 && mac_prec == 2'b10) pad_cnt++;
                if (mac_prec == 2'b00 && mac_activation == 8'h0B) p0_cnt++;
                mcnt = mcnt + 3'd1;
            end else begin
                last_act = 8'h00;
            end
            if (group_done) gd_cnt++;
            if (!in_ready) full_seen++;
            prev_en = mac_en;
        end
    end

    task automatic snap();
        b_en = en_cnt; b_gd = gd_cnt; b_bursts = bursts; b_pad = pad_cnt;
        b_p0 = p0_cnt; b_full = full_seen; b_acc = acc; b_log = log_n;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] w, input logic l);
        bit done = 0;
        @(negedge clk);
        in_valid = 1'b1; in_act = a; in_wgt = w; in_last = l;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check_eq("push_timeout", 1, 0);
    endtask

    task automatic stop_push();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) check_eq("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_act = 8'h00; in_wgt = 8'h00; in_last = 1'b0;
        prec_level = 2'b00;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mac_en", mac_en, 0);
        check_eq("rst_act", mac_activation, 0);
        check_eq("rst_wgt", mac_weight, 0);
        check_eq("rst_prec", mac_prec, 0);
        check_eq("rst_group_done", group_done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // 2: single pair, 8-bit precision
        snap();
        push(8'h05, 8'h03, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t2_pre_pop_mac_en", mac_en, 0);
        check_eq("t2_busy", busy, 1);
        @(negedge clk);
        check_eq("t2_first_mac_en", mac_en, 1);
        check_eq("t2_act", mac_activation, 8'h05);
        check_eq("t2_wgt", mac_weight, 8'h03);
        wait_idle();
        check_eq("t2_en_cycles", en_cnt - b_en, 8);
        check_eq("t2_bursts", bursts - b_bursts, 1);
        check_eq("t2_group_done", gd_cnt - b_gd, 1);
        check_eq("t2_result", acc - b_acc, 15);

        // 3: back-to-back, 2-bit precision
        prec_level = 2'b10;
        snap();
        push(8'h11, 8'h01, 1'b0);
        push(8'h22, 8'h02, 1'b0);
        push(8'h33, 8'h03, 1'b0);
        push(8'h44, 8'h01, 1'b1);
        stop_push();
        wait_idle();
        check_eq("t3_en_cycles", en_cnt - b_en, 8);
        check_eq("t3_contiguous", bursts - b_bursts, 1);
        check_eq("t3_group_done", gd_cnt - b_gd, 1);
        check_eq("t3_pairs", log_n - b_log, 4);
        check_eq("t3_op0", act_log[b_log],     8'h11);
        check_eq("t3_op1", act_log[b_log + 1], 8'h22);
        check_eq("t3_op2", act_log[b_log + 2], 8'h33);
        check_eq("t3_op3", act_log[b_log + 3], 8'h44);

        // 4: FIFO full with 8-bit precision
        prec_level = 2'b00;
        snap();
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i), 8'h01, 1'b0);
        @(negedge clk);
        check_eq("t4_in_ready_full", in_ready, 0);
        push(8'h66, 8'h01, 1'b1);
        stop_push();
        wait_idle();
        check_eq("t4_full_seen", (full_seen - b_full) > 0, 1);
        check_eq("t4_en_cycles", en_cnt - b_en, 48);
        check_eq("t4_pairs", log_n - b_log, 6);
        for (int i = 0; i < 6; i++) check_eq("t4_order", act_log[b_log + i], 8'h61 + 8'(i));
        check_eq("t4_group_done", gd_cnt - b_gd, 1);

        // 5: precision switch forces padding to phase 0
        prec_level = 2'b10;
        push(8'h0A, 8'h01, 1'b1);
        stop_push();
        wait_idle();
        prec_level = 2'b00;
        snap();
        push(8'h0B, 8'h01, 1'b1);
        stop_push();
        wait_idle();
        check_eq("t5_pad_cycles", pad_cnt - b_pad, 6);
        check_eq("t5_issue_cycles", p0_cnt - b_p0, 8);
        check_eq("t5_en_cycles", en_cnt - b_en, 14);
        check_eq("t5_group_done", gd_cnt - b_gd, 1);
        check_eq("t5_final_prec", mac_prec, 0);

        // 6: reset mid-issue
        snap();
        push(8'h71, 8'h01, 1'b1);
        push(8'h72, 8'h01, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !mac_en; i++) @(negedge clk);
        check_eq("t6_started", mac_en, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_mac_en", mac_en, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_in_ready", in_ready, 1);
        check_eq("t6_act", mac_activation, 0);
        repeat (12) @(negedge clk);
        check_eq("t6_no_group_done", gd_cnt - b_gd, 0);
        check_eq("t6_stays_idle", mac_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
